// File: rtl/audio_dsp_pkg.sv
// Shared constants and helpers for the audio moving-average datapath.
package audio_dsp_pkg;

   localparam int DATA_W_DEFAULT = 24;
   localparam int LOG2_N_MIN     = 1;
   localparam int LOG2_N_MAX     = 10;

   // A window of 2^log2_n full-scale samples needs log2_n extra headroom bits.
   function automatic int acc_width(input int data_w, input int log2_n);
      return data_w + log2_n;
   endfunction

endpackage

// File: rtl/avg_ring_buffer.sv
// Per-channel window history and running sum; produces the next output
// sample (average or bypassed input) for the top-level output register.
module avg_ring_buffer
   import audio_dsp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int LOG2_N = 3
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     load,
   input  logic                     primed,
   input  logic                     bypass,
   input  logic [LOG2_N-1:0]        wptr,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] result
);

   localparam int ACC_W = acc_width(DATA_W, LOG2_N);
   localparam int N     = 1 << LOG2_N;

   logic signed [DATA_W-1:0] ring_r [N];
   logic signed [DATA_W-1:0] old_s;
   logic signed [ACC_W-1:0]  acc_r;
   logic signed [ACC_W-1:0]  acc_next_s;

   // Running-sum update; until primed the evicted slot holds stale data and counts as zero.
   always_comb begin
      old_s = {DATA_W{1'b0}};
      if (primed) begin
         old_s = ring_r[wptr];
      end else begin
         old_s = {DATA_W{1'b0}};
      end
      acc_next_s = acc_r + ACC_W'(sample) - ACC_W'(old_s);
      // Dropping the low LOG2_N bits is an arithmetic shift that floors.
      if (bypass) begin
         result = sample;
      end else begin
         result = acc_next_s[ACC_W-1 -: DATA_W];
      end
   end

   // Accumulator register, cleared by reset or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (flush) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (load) begin
         acc_r <= acc_next_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // History storage: no reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (load) begin
         ring_r[wptr] <= sample;
      end
   end

endmodule

// File: rtl/audio_moving_avg.sv
// Multi-channel moving-average filter with valid/ready handshake,
// bypass and flush; one output register stage, one sample per cycle.
module audio_moving_avg
   import audio_dsp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int LOG2_N   = 3,
   parameter int CHANNELS = 2
)
(
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHANNELS*DATA_W-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CHANNELS*DATA_W-1:0] out_data,
   input  logic                       bypass,
   input  logic                       flush,
   output logic                       primed
);

   localparam int              N          = 1 << LOG2_N;
   localparam logic [LOG2_N:0] COUNT_FULL = (LOG2_N + 1)'(N);

   logic [LOG2_N-1:0]          wptr_r;
   logic [LOG2_N:0]            count_r;
   logic [LOG2_N:0]            count_next_s;
   logic                       out_valid_r;
   logic                       primed_r;
   logic [CHANNELS*DATA_W-1:0] out_data_r;
   logic [CHANNELS*DATA_W-1:0] result_s;
   logic                       in_xfer_s;
   logic                       out_xfer_s;

   // Handshake decode and saturating fill count.
   always_comb begin
      in_ready   = ~reset & ~flush & (~out_valid_r | out_ready);
      in_xfer_s  = in_valid & in_ready;
      out_xfer_s = out_valid_r & out_ready;
      if (count_r == COUNT_FULL) begin
         count_next_s = count_r;
      end else begin
         count_next_s = count_r + (LOG2_N + 1)'(1);
      end
   end

   // Pointer, fill state and output register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wptr_r      <= {LOG2_N{1'b0}};
         count_r     <= {(LOG2_N + 1){1'b0}};
         primed_r    <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {(CHANNELS * DATA_W){1'b0}};
      end else if (flush) begin
         wptr_r      <= {LOG2_N{1'b0}};
         count_r     <= {(LOG2_N + 1){1'b0}};
         primed_r    <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (in_xfer_s) begin
         wptr_r      <= wptr_r + LOG2_N'(1);
         count_r     <= count_next_s;
         primed_r    <= (count_next_s == COUNT_FULL);
         out_valid_r <= 1'b1;
         out_data_r  <= result_s;
      end else if (out_xfer_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      avg_ring_buffer #(
         .DATA_W (DATA_W),
         .LOG2_N (LOG2_N)
      ) u_ring (
         .clk    (CLOCK_50),
         .rst    (reset),
         .flush  (flush),
         .load   (in_xfer_s),
         .primed (primed_r),
         .bypass (bypass),
         .wptr   (wptr_r),
         .sample (in_data[c*DATA_W +: DATA_W]),
         .result (result_s[c*DATA_W +: DATA_W])
      );
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign primed    = primed_r;

endmodule

// File: tb/tb_audio_moving_avg.sv
// Scoreboard bench for audio_moving_avg (N=4, 24-bit, stereo) against a
// sliding-window reference model.
module tb_audio_moving_avg;

   localparam int DW = 24;
   localparam int LN = 2;
   localparam int NW = 4;

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [47:0]   in_data  = 48'd0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [47:0]   out_data;
   logic          bypass   = 1'b0;
   logic          flush    = 1'b0;
   logic          primed;

   typedef struct {
      longint l;
      longint r;
   } exp_t;

   exp_t   sb[$];
   longint hl[$];
   longint hr[$];
   int     total_cnt = 0;
   int     pass_cnt  = 0;
   bit     rand_mode = 1'b0;

   audio_moving_avg #(.DATA_W(DW), .LOG2_N(LN), .CHANNELS(2)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .bypass    (bypass),
      .flush     (flush),
      .primed    (primed)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic longint floor_div(input longint s, input longint n);
      longint q;
      q = s / n;
      if ((s % n != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   // Monitor and reference model: checks presented output, then records any accepted input.
   always @(negedge CLOCK_50) begin
      exp_t   e;
      longint sl, sr, l, r;
      if (reset) begin
         hl.delete();
         hr.delete();
         sb.delete();
      end else begin
         chk("in_ready", in_ready, (!flush && (!out_valid || out_ready)));
         chk("out_valid", out_valid, sb.size() != 0);
         chk("primed", primed, hl.size() == NW);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_left", $signed(out_data[23:0]), e.l);
               chk("out_right", $signed(out_data[47:24]), e.r);
            end
         end
         if (flush) begin
            hl.delete();
            hr.delete();
            sb.delete();
         end else if (in_valid && in_ready) begin
            l = $signed(in_data[23:0]);
            r = $signed(in_data[47:24]);
            hl.push_back(l);
            hr.push_back(r);
            if (hl.size() > NW) void'(hl.pop_front());
            if (hr.size() > NW) void'(hr.pop_front());
            sl = 0;
            sr = 0;
            foreach (hl[i]) sl += hl[i];
            foreach (hr[i]) sr += hr[i];
            e.l = bypass ? l : floor_div(sl, NW);
            e.r = bypass ? r : floor_div(sr, NW);
            sb.push_back(e);
         end
      end
   end

   task automatic send(input int l, input int r, input bit byp);
      bit taken;
      int waited;
      logic [23:0] lv;
      logic [23:0] rv;
      lv = l[23:0];
      rv = r[23:0];
      in_valid = 1'b1;
      in_data  = {rv, lv};
      bypass   = byp;
      taken    = 1'b0;
      waited   = 0;
      while (!taken) begin
         @(negedge CLOCK_50);
         taken = in_ready;
         @(posedge CLOCK_50);
         #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
         waited++;
         if (!taken && waited > 100) begin
            chk("send_timeout", 0, 1);
            taken = 1'b1;
         end
      end
      in_valid = 1'b0;
      bypass   = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge CLOCK_50);
      #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   function automatic int rnd_sample();
      logic [31:0] v;
      v = $urandom;
      return int'($signed(v[23:0]));
   endfunction

   initial begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_primed", primed, 0);
      chk("rst_out_data", out_data, 0);
      idle(3);
      reset = 1'b0;
      idle(1);

      // Step response and ramp.
      repeat (6) send(400, -400, 1'b0);
      idle(1);
      do_flush();
      // Wrap of the write pointer.
      for (int i = 1; i <= 6; i++) send(4 * i, -3 * i, 1'b0);
      idle(1);
      do_flush();
      // Floor rounding on negatives.
      send(-1, 1, 1'b0);
      repeat (4) send(0, 0, 1'b0);
      idle(1);
      // Flush mid-stream, then ramp restarts.
      do_flush();
      repeat (6) send(400, 400, 1'b0);
      do_flush();
      repeat (2) send(400, 400, 1'b0);
      idle(1);
      // Bypass while the sum keeps tracking.
      do_flush();
      repeat (3) send(400, -400, 1'b0);
      send(77, -77, 1'b1);
      send(400, -400, 1'b0);
      idle(1);

      // Backpressure: one sample accepted, then stalled for 5 cycles.
      do_flush();
      out_ready = 1'b0;
      send(400, -400, 1'b0);
      in_valid = 1'b1;
      in_data  = {24'hFFFE70, 24'h000190};
      repeat (5) begin
         @(negedge CLOCK_50);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_frozen_left", $signed(out_data[23:0]), 100);
         chk("bp_frozen_right", $signed(out_data[47:24]), -100);
         @(posedge CLOCK_50);
         #1;
      end
      out_ready = 1'b1;
      repeat (3) send(400, -400, 1'b0);
      idle(1);

      // Asynchronous reset between edges.
      repeat (3) send(123, -456, 1'b0);
      @(posedge CLOCK_50);
      #3;
      reset = 1'b1;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_in_ready", in_ready, 0);
      chk("areset_primed", primed, 0);
      chk("areset_out_data", out_data, 0);
      idle(2);
      reset = 1'b0;
      send(400, 400, 1'b0);
      @(negedge CLOCK_50);
      chk("post_reset_ramp", $signed(out_data[23:0]), 100);
      idle(1);

      // Randomized traffic with random backpressure, bypass and flushes.
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 29) == 0) do_flush();
         if ($urandom_range(0, 7) == 0) idle(1);
         send(rnd_sample(), rnd_sample(), $urandom_range(0, 7) == 0);
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      idle(3);
      chk("drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
